// File: rtl/approx_err_pkg.sv
// Shared types and constants for the 4x4 approximate-multiplier error sweep.
// The DIV state exists only when APPROX_REL_ERR_EN is defined.
package approx_err_pkg;

    localparam int N_PAIRS    = 256;
    localparam int DIV_CYCLES = 15;
    localparam int DIVIDEND_W = 15;
    localparam int SUM_REL_W  = 24;
    localparam int SUM_ABS_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
`ifdef APPROX_REL_ERR_EN
        ST_DIV    = 3'd3,
`endif
        ST_ACC    = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/approx_error_sweep_div.sv
// Restoring divider, one quotient bit per cycle; valid pulses the cycle after
// the final step. Only instantiated when APPROX_REL_ERR_EN is defined.
module seq_divider
    import approx_err_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [7:0]            divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  valid
);

    logic [7:0]            rem_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [3:0]            cnt_q;
    logic                  valid_q;
    logic [8:0]            shifted;
    logic [7:0]            trial;

    // Remainder stays below the divisor, so 8 bits plus the shifted-in bit suffice.
    always_comb begin
        shifted = {rem_q, quo_q[DIVIDEND_W-1]};
        trial   = shifted[7:0] - divisor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= dividend;
            cnt_q   <= 4'(DIV_CYCLES);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            if (shifted >= {1'b0, divisor}) begin
                rem_q <= trial;
                quo_q <= {quo_q[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_q <= shifted[7:0];
                quo_q <= {quo_q[DIVIDEND_W-2:0], 1'b0};
            end
            cnt_q   <= cnt_q - 4'd1;
            valid_q <= (cnt_q == 4'd1);
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign quotient = quo_q;
    assign valid    = valid_q;

endmodule

// File: rtl/approx_error_sweep.sv
// Sweeps all 256 operand pairs through the 4x4 multiplier and accumulates error
// statistics. Relative error (divider + DIV state) only with APPROX_REL_ERR_EN.
module approx_error_sweep
    import approx_err_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [3:0]           op_a,
    output logic [3:0]           op_b,
    input  logic [7:0]           approx_p,
    output logic                 busy,
    output logic                 done,
    output logic [SUM_ABS_W-1:0] sum_abs_err,
    output logic [7:0]           max_abs_err,
    output logic [8:0]           err_count,
    output logic [SUM_REL_W-1:0] rel_err_sum
);

    state_e               state_q, state_d;
    logic [7:0]           idx_q;
    logic [7:0]           op_q;
    logic [7:0]           d_q;
    logic                 busy_q;
    logic                 done_q;
    logic [SUM_ABS_W-1:0] sum_q;
    logic [7:0]           max_q;
    logic [8:0]           cnt_q;
    logic [7:0]           exact_w;
    logic [7:0]           diff_w;

    always_comb begin
        exact_w = {4'd0, op_q[7:4]} * {4'd0, op_q[3:0]};
        diff_w  = (approx_p >= exact_w) ? (approx_p - exact_w) : (exact_w - approx_p);
    end

`ifdef APPROX_REL_ERR_EN
    logic [SUM_REL_W-1:0]  rel_q;
    logic [3:0]            div_cnt_q;
    logic                  div_start;
    logic                  div_valid;
    logic [DIVIDEND_W-1:0] div_quo;
    logic [DIVIDEND_W-1:0] dividend_w;

    assign dividend_w = {7'd0, diff_w} * 15'd100;
    assign div_start  = (state_q == ST_SAMPLE) && (state_d == ST_DIV);

    seq_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dividend_w),
        .divisor  (exact_w),
        .quotient (div_quo),
        .valid    (div_valid)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SAMPLE;
`ifdef APPROX_REL_ERR_EN
            ST_SAMPLE: state_d = (exact_w != '0 && diff_w != '0) ? ST_DIV : ST_ACC;
            ST_DIV:    if (div_cnt_q == 4'(DIV_CYCLES - 1)) state_d = ST_ACC;
`else
            ST_SAMPLE: state_d = ST_ACC;
`endif
            ST_ACC:    state_d = (idx_q == 8'(N_PAIRS - 1)) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            op_q   <= '0;
            d_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            max_q  <= '0;
            cnt_q  <= '0;
`ifdef APPROX_REL_ERR_EN
            rel_q     <= '0;
            div_cnt_q <= '0;
`endif
        end else begin
            done_q <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: if (start) begin
                    idx_q  <= '0;
                    busy_q <= 1'b1;
                    sum_q  <= '0;
                    max_q  <= '0;
                    cnt_q  <= '0;
`ifdef APPROX_REL_ERR_EN
                    rel_q  <= '0;
`endif
                end
                ST_DRIVE: op_q <= idx_q;
                ST_SAMPLE: begin
                    d_q <= diff_w;
`ifdef APPROX_REL_ERR_EN
                    div_cnt_q <= '0;
`endif
                end
`ifdef APPROX_REL_ERR_EN
                ST_DIV: div_cnt_q <= div_cnt_q + 4'd1;
`endif
                ST_ACC: begin
                    sum_q <= sum_q + {8'd0, d_q};
                    if (d_q > max_q) max_q <= d_q;
                    cnt_q <= cnt_q + {8'd0, (d_q != '0)};
`ifdef APPROX_REL_ERR_EN
                    // The divider's valid pulse lands exactly on the ACC cycle of a divided pair.
                    if (div_valid) rel_q <= rel_q + {9'd0, div_quo};
`endif
                    idx_q <= idx_q + 8'd1;
                end
                ST_DONE: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign op_a        = op_q[7:4];
    assign op_b        = op_q[3:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;
    assign err_count   = cnt_q;
`ifdef APPROX_REL_ERR_EN
    assign rel_err_sum = rel_q;
`else
    assign rel_err_sum = '0;
`endif

endmodule

// File: doc/approx_error_sweep.md
# approx_error_sweep

- Hardware characterisation engine for the 4x4 approximate multiplier.
- Generates all 256 operand pairs, drives them to a `multiplier_4x4` instance and consumes its product.
- Compares each product against the exact product and accumulates absolute-error and relative-error statistics.
- Sits directly around the multiplier, in place of a simulation-only testbench, so error metrics can be measured on silicon/FPGA.

## Interface
Parameters: none; all widths fixed by the 4x4 multiplier.

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — begin sweep; sampled only in IDLE
- `op_a` out 4 — operand A to multiplier (registered)
- `op_b` out 4 — operand B to multiplier (registered)
- `approx_p` in 8 — multiplier product, combinational from `op_a`/`op_b`
- `busy` out 1 — high from the cycle after `start` is accepted until DONE
- `done` out 1 — one-cycle pulse when results are final
- `sum_abs_err` out 16 — Σ|approx−exact| over all 256 pairs
- `max_abs_err` out 8 — largest |approx−exact|
- `err_count` out 9 — number of pairs with approx≠exact (0..256)
- `rel_err_sum` out 24 — Σ floor(|d|·100/exact) over pairs with exact≠0; equals the mean relative error in percent as Q16.8

## Operation
- Pair index `idx` is 8 bits: `op_a = idx[7:4]`, `op_b = idx[3:0]`, swept 0..255 in order.
- FSM states: IDLE, DRIVE, SAMPLE, DIV, ACC, DONE.
- IDLE: on `start`=1, clear all accumulators, set `idx`=0, go to DRIVE.
- DRIVE: `op_a`/`op_b` are updated from `idx`. One cycle of settle time for the multiplier.
- SAMPLE: register `approx_p`. Compute exact = op_a·op_b (8 bit) and d = |approx_p − exact| (8 bit).
  - If exact==0 or d==0, rel = 0 and go to ACC.
  - Otherwise go to DIV.
- DIV: restoring divide of the 15-bit dividend d·100 (≤25500) by the 8-bit divisor exact. One quotient bit per cycle, 15 cycles. Quotient ≤25500.
- ACC:
  - sum_abs_err += d
  - max_abs_err = max(max_abs_err, d)
  - err_count += (d≠0)
  - rel_err_sum += rel
  - If idx==255, go to DONE. Otherwise increment idx and go to DRIVE.
- DONE: `done`=1 for one cycle, then IDLE. Results hold until the next accepted `start` or reset.
- Exact==0 pairs still contribute to sum_abs_err, max_abs_err and err_count.
- `start` while busy is ignored.
- `start` held high through DONE→IDLE triggers a new sweep from IDLE.
- No accumulator can overflow at these widths. No saturation logic.

## Timing
- Reset value of every output is 0: `op_a`, `op_b`, `busy`, `done` and all statistics. FSM resets to IDLE.
- Reset asserted mid-sweep aborts immediately, with no partial results retained.
- Per-pair cost:
  - 3 cycles (DRIVE, SAMPLE, ACC) when exact==0 or d==0.
  - 18 cycles otherwise (DRIVE, SAMPLE, 15×DIV, ACC).
- `approx_p` is sampled exactly one cycle after `op_a`/`op_b` change. The multiplier must be single-cycle combinational.
- Statistics outputs are valid only once `done` is seen. They update during the sweep.
- `done` rises T cycles after the start edge, where T = 1 + 3·n_fast + 18·n_slow.
  - For an exact multiplier, T = 769.

## Configuration
- `APPROX_REL_ERR_EN` defined: DIV state and divider are compiled in; `rel_err_sum` is computed as above.
- Not defined: no divider and no DIV state; every pair takes 3 cycles (sweep T = 769); `rel_err_sum` is tied to 0.

## Structure
- Package `approx_err_pkg` holds:
  - FSM state enum
  - `N_PAIRS=256`
  - `DIV_CYCLES=15`
  - widths: `DIVIDEND_W=15`, `SUM_REL_W=24`, `SUM_ABS_W=16`
- Sub-module `seq_divider` (only under `APPROX_REL_ERR_EN`):
  - interface: `clk`, `rst_n`, `start`, dividend[14:0], divisor[7:0], quotient[14:0], `valid`
  - restoring algorithm, valid pulses after 15 cycles
- Top-level bench ties `op_a`/`op_b`/`approx_p` to `multiplier_4x4`.

## Test plan
- Multiplier replaced by exact model (p = a·b), start pulse → all statistics 0, `done` rises at cycle 769.
- Model p = 0 → sum_abs_err = 14400, max_abs_err = 225, err_count = 225, rel_err_sum = 22500 (100% mean-of-nonzero; 87.89 as Q16.8).
- Model p = 255 → sum_abs_err = 50880, max_abs_err = 255, err_count = 256.
- Model exact except (3,5)→14 and (1,1)→2 → sum_abs_err = 2, max_abs_err = 1, err_count = 2, rel_err_sum = 106 (6 + 100); `done` at 769 + 2·15 = 799.
- Drop `rst_n` at cycle 400 of a sweep → all outputs 0 and busy = 0 asynchronously. New start reproduces the full-sweep results.
- `start` pulsed at cycle 50 mid-sweep → ignored; `done` timing and results unchanged. Build without `APPROX_REL_ERR_EN` on the p = 0 model → rel_err_sum = 0, `done` at 769.
